// File: rtl/pulse_divider_pkg.sv
// Shared types and helpers for the pulse divider.
package pulse_divider_pkg;

  localparam int unsigned DATA_W = 32;

  // Bit 1 drives outd_o and bit 0 drives outn_o, so the two outputs come
  // straight off the route register and can never be high together.
  typedef enum logic [1:0] {
    ROUTE_NONE = 2'b00,
    ROUTE_N    = 2'b01,
    ROUTE_D    = 2'b10
  } route_e;

  // A divisor of zero behaves as divide-by-one.
  function automatic logic [DATA_W-1:0] eff_divisor(input logic [DATA_W-1:0] divisor);
    eff_divisor = (divisor == '0) ? DATA_W'(1) : divisor;
  endfunction

  // Counter start value: 0, or D-1 so that the very first pulse matches.
  function automatic logic [DATA_W-1:0] start_value(input logic [DATA_W-1:0] divisor,
                                                    input logic              first_pulse);
    start_value = first_pulse ? (eff_divisor(divisor) - DATA_W'(1)) : '0;
  endfunction

endpackage

// File: rtl/pulse_divider_if.sv
// Pulse and register-bus signals of the pulse divider.
//   master : drives inp_i, enable_i, FIRST_PULSE(+_WSTB), DIVISOR(+_WSTB);
//            observes outd_o, outn_o, COUNT
//   slave  : the divider itself
interface pulse_divider_if;
  import pulse_divider_pkg::*;

  logic              inp_i;
  logic              enable_i;
  logic              FIRST_PULSE;
  logic              FIRST_PULSE_WSTB;
  logic [DATA_W-1:0] DIVISOR;
  logic              DIVISOR_WSTB;
  logic              outd_o;
  logic              outn_o;
  logic [DATA_W-1:0] COUNT;

  modport master (
    output inp_i, enable_i, FIRST_PULSE, FIRST_PULSE_WSTB, DIVISOR, DIVISOR_WSTB,
    input  outd_o, outn_o, COUNT
  );

  modport slave (
    input  inp_i, enable_i, FIRST_PULSE, FIRST_PULSE_WSTB, DIVISOR, DIVISOR_WSTB,
    output outd_o, outn_o, COUNT
  );

endinterface

// File: rtl/pulse_divider_rising_edge_detect.sv
// Single-bit rising edge detector.
//   clk_i   : clock
//   reset_i : asynchronous active-high reset (clears the history bit)
//   sig_i   : signal to watch
//   rise_c  : combinational, high when sig_i is 1 and was 0 last cycle
module pulse_divider_rising_edge_detect (
  input  logic clk_i,
  input  logic reset_i,
  input  logic sig_i,
  output logic rise_c
);

  logic prev_q;
  logic prev_d;

  always_comb begin
    prev_d = sig_i;
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      prev_q <= 1'b0;
    end else begin
      prev_q <= prev_d;
    end
  end

  assign rise_c = sig_i & ~prev_q;

endmodule

// File: rtl/pulse_divider.sv
// Pulse divider: every DIVISOR-th rising pulse of inp_i is steered to outd_o,
// all others to outn_o, each output pulse as wide as its input pulse and
// delayed by one clock.
//   clk_i   : clock
//   reset_i : asynchronous active-high reset
//   bus     : pulse_divider_if.slave (inputs, strobes, outputs, COUNT)
module pulse_divider
  import pulse_divider_pkg::*;
(
  input  logic            clk_i,
  input  logic            reset_i,
  pulse_divider_if.slave  bus
);

  logic [DATA_W-1:0] count_q;
  logic [DATA_W-1:0] count_d;
  route_e            route_q;
  route_e            route_d;

  logic              rise_c;
  logic              load_c;
  logic [DATA_W-1:0] last_c;
  logic [DATA_W-1:0] start_c;

  pulse_divider_rising_edge_detect u_edge (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .sig_i   (bus.inp_i),
    .rise_c  (rise_c)
  );

  assign last_c  = eff_divisor(bus.DIVISOR) - DATA_W'(1);
  assign start_c = start_value(bus.DIVISOR, bus.FIRST_PULSE);
  assign load_c  = ~bus.enable_i | bus.DIVISOR_WSTB | bus.FIRST_PULSE_WSTB;

  // Next counter/route: loads outrank edges; a routed pulse is held until
  // inp_i is sampled low.
  always_comb begin
    count_d = count_q;
    route_d = route_q;
    if (load_c) begin
      count_d = start_c;
      route_d = ROUTE_NONE;
    end else if (rise_c) begin
      if (count_q == last_c) begin
        count_d = '0;
        route_d = ROUTE_D;
      end else begin
        count_d = count_q + DATA_W'(1);
        route_d = ROUTE_N;
      end
    end else if (!bus.inp_i) begin
      route_d = ROUTE_NONE;
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      count_q <= '0;
      route_q <= ROUTE_NONE;
    end else begin
      count_q <= count_d;
      route_q <= route_d;
    end
  end

  assign bus.outd_o = route_q[1];
  assign bus.outn_o = route_q[0];
  assign bus.COUNT  = count_q;

endmodule

// File: tb/tb_pulse_divider.sv
// Directed bench for pulse_divider.
module tb_pulse_divider;
  import pulse_divider_pkg::*;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  pulse_divider_if bus ();

  pulse_divider dut (
    .clk_i   (clk),
    .reset_i (rst),
    .bus     (bus.slave)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic exp_d, input logic exp_n,
                         input logic [31:0] exp_count);
    chk({tag, ".outd"}, 32'(bus.outd_o), 32'(exp_d));
    chk({tag, ".outn"}, 32'(bus.outn_o), 32'(exp_n));
    chk({tag, ".count"}, bus.COUNT, exp_count);
  endtask

  // Two-cycle input pulse followed by a two-cycle gap.
  task automatic pulse(input string tag, input logic exp_d, input logic exp_n,
                       input logic [31:0] exp_count);
    bus.inp_i = 1'b1;
    step();
    chk_out({tag, ".c1"}, exp_d, exp_n, exp_count);
    step();
    chk_out({tag, ".c2"}, exp_d, exp_n, exp_count);
    bus.inp_i = 1'b0;
    step();
    chk_out({tag, ".lo"}, 1'b0, 1'b0, exp_count);
    step();
  endtask

  task automatic strobe_div(input logic [31:0] div);
    bus.DIVISOR      = div;
    bus.DIVISOR_WSTB = 1'b1;
    step();
    bus.DIVISOR_WSTB = 1'b0;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst                  = 1'b1;
    bus.inp_i            = 1'b0;
    bus.enable_i         = 1'b0;
    bus.FIRST_PULSE      = 1'b0;
    bus.FIRST_PULSE_WSTB = 1'b0;
    bus.DIVISOR          = 32'd0;
    bus.DIVISOR_WSTB     = 1'b0;
    step();
    step();
    chk_out("reset", 1'b0, 1'b0, 32'd0);
    rst = 1'b0;

    // Divide by 3, OutN first
    bus.enable_i = 1'b1;
    strobe_div(32'd3);
    chk("div3.start", bus.COUNT, 32'd0);
    pulse("div3.p1", 1'b0, 1'b1, 32'd1);
    pulse("div3.p2", 1'b0, 1'b1, 32'd2);
    pulse("div3.p3", 1'b1, 1'b0, 32'd0);
    pulse("div3.p4", 1'b0, 1'b1, 32'd1);
    pulse("div3.p5", 1'b0, 1'b1, 32'd2);
    pulse("div3.p6", 1'b1, 1'b0, 32'd0);

    // OutD first, divide by 4
    bus.DIVISOR          = 32'd4;
    bus.FIRST_PULSE      = 1'b1;
    bus.FIRST_PULSE_WSTB = 1'b1;
    step();
    bus.FIRST_PULSE_WSTB = 1'b0;
    chk("first.start", bus.COUNT, 32'd3);
    pulse("first.p1", 1'b1, 1'b0, 32'd0);
    pulse("first.p2", 1'b0, 1'b1, 32'd1);
    pulse("first.p3", 1'b0, 1'b1, 32'd2);
    pulse("first.p4", 1'b0, 1'b1, 32'd3);
    pulse("first.p5", 1'b1, 1'b0, 32'd0);

    // Enable gating
    bus.FIRST_PULSE = 1'b0;
    bus.enable_i    = 1'b0;
    step();
    chk("en.off", bus.COUNT, 32'd0);
    pulse("en.off.p", 1'b0, 1'b0, 32'd0);
    bus.enable_i = 1'b1;
    bus.inp_i    = 1'b1;
    step();
    chk_out("en.mid.hi", 1'b0, 1'b1, 32'd1);
    bus.enable_i = 1'b0;
    step();
    chk_out("en.mid.drop", 1'b0, 1'b0, 32'd0);
    bus.enable_i = 1'b1;
    step();
    chk_out("en.rise.hi_in", 1'b0, 1'b0, 32'd0);
    step();
    chk_out("en.rise.hold", 1'b0, 1'b0, 32'd0);
    bus.inp_i = 1'b0;
    step();
    step();
    pulse("en.after", 1'b0, 1'b1, 32'd1);

    // Strobe restart
    strobe_div(32'd3);
    chk("rst3.start", bus.COUNT, 32'd0);
    pulse("rst3.p1", 1'b0, 1'b1, 32'd1);
    pulse("rst3.p2", 1'b0, 1'b1, 32'd2);
    strobe_div(32'd5);
    chk("div5.start", bus.COUNT, 32'd0);
    pulse("div5.p1", 1'b0, 1'b1, 32'd1);
    pulse("div5.p2", 1'b0, 1'b1, 32'd2);
    pulse("div5.p3", 1'b0, 1'b1, 32'd3);
    pulse("div5.p4", 1'b0, 1'b1, 32'd4);
    pulse("div5.p5", 1'b1, 1'b0, 32'd0);

    // Strobe coincident with an input edge
    pulse("coin.pre", 1'b0, 1'b1, 32'd1);
    bus.inp_i        = 1'b1;
    bus.DIVISOR_WSTB = 1'b1;
    step();
    bus.DIVISOR_WSTB = 1'b0;
    chk_out("coin.edge", 1'b0, 1'b0, 32'd0);
    step();
    chk_out("coin.hold", 1'b0, 1'b0, 32'd0);
    bus.inp_i = 1'b0;
    step();
    step();

    // DIVISOR 0 and 1: every pulse to outd_o
    strobe_div(32'd0);
    pulse("div0.p1", 1'b1, 1'b0, 32'd0);
    pulse("div0.p2", 1'b1, 1'b0, 32'd0);
    strobe_div(32'd1);
    pulse("div1.p1", 1'b1, 1'b0, 32'd0);
    pulse("div1.p2", 1'b1, 1'b0, 32'd0);

    // Async reset mid-pulse
    strobe_div(32'd3);
    pulse("ar.p1", 1'b0, 1'b1, 32'd1);
    bus.inp_i = 1'b1;
    step();
    chk_out("ar.hi", 1'b0, 1'b1, 32'd2);
    #2;
    rst = 1'b1;
    #1;
    chk_out("ar.async", 1'b0, 1'b0, 32'd0);
    bus.inp_i = 1'b0;
    step();
    rst = 1'b0;
    step();
    pulse("ar.resume1", 1'b0, 1'b1, 32'd1);
    pulse("ar.resume2", 1'b0, 1'b1, 32'd2);
    pulse("ar.resume3", 1'b1, 1'b0, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pulse_divider.md
Name: pulse_divider

Overview:
- Pulse divider block for the position/trigger fabric.
- Every rising edge of inp_i while enabled is counted. Each complete input pulse is steered to one of two outputs:
  - outd_o receives every DIVISOR-th pulse.
  - outn_o receives all other pulses.
- Divisor, first-pulse polarity and a live count are exposed as register-bus fields with write strobes.

Parameters:
- None. All widths are fixed at 32 bits.

Ports:
- clk_i  in  1  system clock; all logic is on its rising edge
- reset_i  in  1  asynchronous, active-high reset
- inp_i  in  1  pulse input to divide
- enable_i  in  1  block enable; low holds the counter at its start value and forces outputs low
- FIRST_PULSE  in  1  0 = first DIVISOR-1 pulses go to outn_o; 1 = first pulse goes to outd_o
- FIRST_PULSE_WSTB  in  1  write strobe for FIRST_PULSE; restarts the counter
- DIVISOR  in  32  unsigned divide ratio
- DIVISOR_WSTB  in  1  write strobe for DIVISOR; restarts the counter
- outd_o  out  1  divided pulse output
- outn_o  out  1  non-divided (remaining) pulse output
- COUNT  out  32  current counter value, readable on the register bus

Behaviour:
- Reset (reset_i high, asynchronous): counter = 0; outd_o = outn_o = 0; COUNT = 0; the inp_i edge-detect register = 0.
- Effective divisor: D = DIVISOR, or D = 1 when DIVISOR is 0.
- Start value: S = 0 if FIRST_PULSE = 0; S = D-1 if FIRST_PULSE = 1.
- Counter loading:
  - Loaded with S on any cycle where enable_i = 0, DIVISOR_WSTB = 1 or FIRST_PULSE_WSTB = 1.
  - A strobe outranks a coincident input edge: the edge is ignored and both outputs are driven low that cycle.
- Edge detect: inp_prev registers inp_i every cycle; rise = inp_i AND NOT inp_prev.
- On a rise while enabled and with no strobe:
  - If counter = D-1: counter becomes 0, route = D, outd_o goes 1.
  - Otherwise: counter increments, route = N, outn_o goes 1.
- Pulse width:
  - The selected output stays 1 while inp_i stays 1.
  - It drops on the first clock edge that samples inp_i = 0.
  - Output pulse width equals input pulse width.
- Latency: exactly 1 clock from an inp_i change (sampled) to the output change.
- Only the routed output is ever high; outd_o and outn_o are never high together.
- enable_i falling mid-pulse: both outputs go 0 at the next edge and the counter reloads S.
- enable_i rising while inp_i is already high: this is not a rise. No output until the next rising edge of inp_i.
- COUNT is the registered counter value, updated on the same edge as the counter.
- DIVISOR/FIRST_PULSE values are sampled combinationally each cycle. Changes without a strobe take effect at the next comparison and do not restart the counter.
- Counter compare uses unsigned 32-bit arithmetic. The counter never exceeds D-1 except after a DIVISOR decrease without a strobe; in that case it counts up to wrap (2^32-1 -> 0) before matching. Strobes prevent this case.

Decomposition:
- No shared package needed; the only constant is the 32-bit width.
- Optional sub-module: rising_edge_detect (1-bit register + AND), reusable across blocks.
- Counter, routing and output registers live in the top-level block.

Test Plan:
- Divide by 3, OutN first: DIVISOR=3 + strobe, FIRST_PULSE=0, enable=1, six 2-cycle pulses.
  - Routing: N,N,D,N,N,D.
  - COUNT sequence: 1,2,0,1,2,0.
  - Each output pulse is 2 cycles wide and delayed by 1 cycle.
- OutD first: FIRST_PULSE=1 + strobe, DIVISOR=4, five pulses.
  - Routing: D,N,N,N,D.
  - COUNT after the first pulse = 0.
- Enable gating:
  - Pulses with enable=0 produce no output and COUNT stays at S.
  - Dropping enable mid-pulse clears the output next cycle; re-enabling restarts from S.
- Strobe restart: after 2 of 3 pulses (COUNT=2), pulse DIVISOR_WSTB with DIVISOR=5.
  - COUNT=0 next cycle.
  - The next 4 pulses go to N, the 5th goes to D.
- DIVISOR=0 and DIVISOR=1: every pulse goes to outd_o; COUNT stays 0.
- Async reset asserted mid-pulse: outputs and COUNT go 0 immediately (no clock needed); normal operation resumes after deassert.
